// File: rtl/fir_uart_tx.sv
// Buffers FIR output samples in a small circular FIFO and serialises them as
// 8N1 UART frames; consecutive samples go out back-to-back with no idle gap.
module fir_uart_tx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [7:0]                    sample_in,
    input  logic                          sample_valid,
    input  logic                          clr_ovf,
    output logic                          tx,
    output logic                          busy,
    output logic                          fifo_full,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(FIFO_DEPTH);
    localparam logic [7:0]       BAUD_LAST  = 8'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [7:0]         mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [7:0]         shift_reg;
    logic [7:0]         baud_cnt;
    logic [2:0]         bit_idx;
    logic               push;
    logic               pop;
    logic               drop;
    logic               fifo_empty;
    logic               baud_done;
    logic               tx_next;

    assign fifo_empty = (fifo_count == '0);
    assign fifo_full  = (fifo_count == FULL_COUNT);
    assign baud_done  = (baud_cnt == BAUD_LAST);
    assign busy       = (state != IDLE);

    // A pop in the same cycle frees a slot, so a push into a full FIFO is
    // only dropped when nothing leaves it.
    assign push = sample_valid && (!fifo_full || pop);
    assign drop = sample_valid && fifo_full && !pop;

    always_comb begin
        state_next = state;
        pop        = 1'b0;
        tx_next    = 1'b1;
        case (state)
            IDLE: begin
                tx_next = 1'b1;
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    state_next = START;
                end
            end
            START: begin
                tx_next = 1'b0;
                if (baud_done) begin
                    state_next = DATA;
                end
            end
            DATA: begin
                tx_next = shift_reg[0];
                if (baud_done && (bit_idx == 3'd7)) begin
                    state_next = STOP;
                end
            end
            STOP: begin
                tx_next = 1'b1;
                if (baud_done) begin
                    if (!fifo_empty) begin
                        pop        = 1'b1;
                        state_next = START;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // tx is registered, so the line follows the state one cycle later; this
    // keeps the output glitch-free and gives the two-edge start latency.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            tx        <= 1'b1;
            baud_cnt  <= '0;
            bit_idx   <= '0;
            shift_reg <= '0;
        end else begin
            state <= state_next;
            tx    <= tx_next;

            if ((state == IDLE) || baud_done) begin
                baud_cnt <= '0;
            end else begin
                baud_cnt <= baud_cnt + 8'd1;
            end

            if (pop) begin
                bit_idx   <= '0;
                shift_reg <= mem[rd_ptr];
            end else if ((state == DATA) && baud_done) begin
                bit_idx   <= bit_idx + 3'd1;
                shift_reg <= {1'b0, shift_reg[7:1]};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && push) begin
            mem[wr_ptr] <= sample_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CNT_W'(1);
                2'b01:   fifo_count <= fifo_count - CNT_W'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // A drop in the same cycle as a clear leaves the flag set.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (clr_ovf) begin
            overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fir_uart_tx.sv
// Directed bench for fir_uart_tx: a cycle-counting UART receiver decodes the
// line, and immediate assertions compare against hand-computed values.
module tb_fir_uart_tx;

    localparam int CPB   = 16;
    localparam int DEPTH = 4;
    localparam int FRAME = 10 * CPB;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] sample_in;
    logic       sample_valid;
    logic       clr_ovf;
    logic       tx;
    logic       busy;
    logic       fifo_full;
    logic [2:0] fifo_count;
    logic       overflow;

    int assert_count = 0;
    int fail_count   = 0;
    int cycle        = 0;
    int frame_err    = 0;

    logic [7:0] rx_q[$];
    int         start_q[$];

    logic [7:0] exp_ovf  [5] = '{8'h77, 8'h10, 8'h11, 8'h12, 8'h13};
    logic [7:0] exp_full [6] = '{8'h20, 8'h21, 8'h22, 8'h23, 8'h24, 8'h55};

    fir_uart_tx #(
        .CLKS_PER_BIT(CPB),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .sample_in   (sample_in),
        .sample_valid(sample_valid),
        .clr_ovf     (clr_ovf),
        .tx          (tx),
        .busy        (busy),
        .fifo_full   (fifo_full),
        .fifo_count  (fifo_count),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    // Receiver: sample each bit at its centre, counting from the first low cycle.
    initial begin : uart_monitor
        bit         active;
        int         cnt;
        int         start_cycle;
        logic [7:0] rx_byte;
        active = 1'b0;
        cnt = 0;
        start_cycle = 0;
        rx_byte = '0;
        forever begin
            @(negedge clk);
            if (rst === 1'b1) begin
                active = 1'b0;
            end else if (!active) begin
                if (tx === 1'b0) begin
                    active      = 1'b1;
                    cnt         = 0;
                    start_cycle = cycle;
                end
            end else begin
                cnt++;
                if (cnt == CPB / 2 && tx !== 1'b0) frame_err++;
                if (cnt >= CPB / 2 + CPB && cnt <= CPB / 2 + 8 * CPB && ((cnt - CPB / 2) % CPB) == 0)
                    rx_byte[(cnt - CPB / 2) / CPB - 1] = tx;
                if (cnt == CPB / 2 + 9 * CPB) begin
                    if (tx !== 1'b1) frame_err++;
                    rx_q.push_back(rx_byte);
                    start_q.push_back(start_cycle);
                    active = 1'b0;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assert_count++;
        assert (observed === expected) else begin
            fail_count++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] data);
        sample_in    = data;
        sample_valid = 1'b1;
        tick();
        sample_valid = 1'b0;
    endtask

    function automatic logic [7:0] rxAt(input int i);
        if (i < rx_q.size()) return rx_q[i];
        return 8'hxx;
    endfunction

    function automatic int startAt(input int i);
        if (i < start_q.size()) return start_q[i];
        return -1;
    endfunction

    task automatic waitRx(input string tag, input int n, input int limit);
        for (int i = 0; i < limit && rx_q.size() < n; i++) tick();
        checkOutput(tag, rx_q.size(), n);
        checkOutput({tag, "_framing"}, frame_err, 0);
    endtask

    task automatic clearRx();
        rx_q.delete();
        start_q.delete();
    endtask

    initial begin
        int tx_low;
        rst          = 1'b1;
        sample_in    = 8'h00;
        sample_valid = 1'b0;
        clr_ovf      = 1'b0;
        tick();
        tick();
        checkOutput("reset_tx", tx, 1);
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_count", fifo_count, 0);
        checkOutput("reset_full", fifo_full, 0);
        checkOutput("reset_ovf", overflow, 0);
        rst = 1'b0;

        // Data without a strobe is ignored.
        sample_in = 8'hEE;
        repeat (3) tick();
        checkOutput("ignore_count", fifo_count, 0);
        checkOutput("ignore_busy", busy, 0);

        // Single byte 0xA5 and its latency.
        applyStimulus(8'hA5);
        checkOutput("single_count_e", fifo_count, 1);
        checkOutput("single_busy_e", busy, 0);
        checkOutput("single_tx_e", tx, 1);
        tick();
        checkOutput("single_count_e1", fifo_count, 0);
        checkOutput("single_busy_e1", busy, 1);
        checkOutput("single_tx_e1", tx, 1);
        tick();
        checkOutput("single_tx_e2", tx, 0);
        repeat (FRAME - 2) tick();
        checkOutput("single_busy_e160", busy, 1);
        tick();
        checkOutput("single_busy_e161", busy, 0);
        waitRx("single_rx", 1, 200);
        checkOutput("single_byte", rxAt(0), 8'hA5);
        repeat (4) tick();
        clearRx();

        // Three back-to-back samples.
        sample_valid = 1'b1;
        sample_in = 8'h01;
        tick();
        checkOutput("b2b_count0", fifo_count, 1);
        sample_in = 8'h02;
        tick();
        checkOutput("b2b_count1", fifo_count, 1);
        sample_in = 8'h03;
        tick();
        sample_valid = 1'b0;
        checkOutput("b2b_count_peak", fifo_count, 2);
        waitRx("b2b_rx", 3, 3 * FRAME + 100);
        checkOutput("b2b_byte0", rxAt(0), 8'h01);
        checkOutput("b2b_byte1", rxAt(1), 8'h02);
        checkOutput("b2b_byte2", rxAt(2), 8'h03);
        checkOutput("b2b_gap01", startAt(1) - startAt(0), FRAME);
        checkOutput("b2b_gap12", startAt(2) - startAt(1), FRAME);
        repeat (20) tick();
        checkOutput("b2b_idle", busy, 0);
        clearRx();

        // Overflow while a byte is in flight, then clear.
        applyStimulus(8'h77);
        tick();
        tick();
        checkOutput("ovf_inflight", busy, 1);
        sample_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            sample_in = 8'h10 + 8'(k);
            tick();
        end
        checkOutput("ovf_count4", fifo_count, 4);
        checkOutput("ovf_full", fifo_full, 1);
        checkOutput("ovf_flag_before", overflow, 0);
        sample_in = 8'h14;
        tick();
        sample_valid = 1'b0;
        checkOutput("ovf_count_drop", fifo_count, 4);
        checkOutput("ovf_flag_set", overflow, 1);
        clr_ovf = 1'b1;
        applyStimulus(8'h99);
        checkOutput("ovf_set_wins", overflow, 1);
        checkOutput("ovf_count_setwins", fifo_count, 4);
        tick();
        clr_ovf = 1'b0;
        checkOutput("ovf_cleared", overflow, 0);
        waitRx("ovf_rx", 5, 5 * FRAME + 200);
        for (int i = 0; i < 5; i++) checkOutput("ovf_order", rxAt(i), exp_ovf[i]);
        repeat (30) tick();
        checkOutput("ovf_no_extra", rx_q.size(), 5);
        checkOutput("ovf_idle", busy, 0);
        clearRx();

        // Push into a full FIFO on the STOP-final cycle.
        applyStimulus(8'h20);
        sample_valid = 1'b1;
        for (int k = 1; k < 5; k++) begin
            sample_in = 8'h20 + 8'(k);
            tick();
        end
        sample_valid = 1'b0;
        checkOutput("fpp_count_full", fifo_count, 4);
        repeat (FRAME - 4) tick();
        checkOutput("fpp_count_pre", fifo_count, 4);
        checkOutput("fpp_busy_pre", busy, 1);
        applyStimulus(8'h55);
        checkOutput("fpp_count_post", fifo_count, 4);
        checkOutput("fpp_full_post", fifo_full, 1);
        checkOutput("fpp_no_ovf", overflow, 0);
        waitRx("fpp_rx", 6, 6 * FRAME + 200);
        for (int i = 0; i < 6; i++) checkOutput("fpp_order", rxAt(i), exp_full[i]);
        repeat (30) tick();
        checkOutput("fpp_idle", busy, 0);
        clearRx();

        // Reset during DATA bit 3 of 0xFF with two entries queued.
        applyStimulus(8'hFF);
        sample_valid = 1'b1;
        sample_in = 8'h31;
        tick();
        sample_in = 8'h32;
        tick();
        sample_valid = 1'b0;
        checkOutput("rst_queued", fifo_count, 2);
        repeat (67) tick();
        rst = 1'b1;
        clr_ovf = 1'b1;
        applyStimulus(8'h44);
        rst = 1'b0;
        clr_ovf = 1'b0;
        checkOutput("rst_tx", tx, 1);
        checkOutput("rst_count", fifo_count, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_full", fifo_full, 0);
        tx_low = 0;
        for (int i = 0; i < 400; i++) begin
            tick();
            if (tx !== 1'b1) tx_low++;
        end
        checkOutput("rst_line_quiet", tx_low, 0);
        checkOutput("rst_no_frames", rx_q.size(), 0);
        checkOutput("rst_still_idle", busy, 0);

        // First sample after reset keeps the original latency.
        applyStimulus(8'h3C);
        checkOutput("post_rst_count_e", fifo_count, 1);
        tick();
        checkOutput("post_rst_busy_e1", busy, 1);
        checkOutput("post_rst_tx_e1", tx, 1);
        tick();
        checkOutput("post_rst_tx_e2", tx, 0);
        waitRx("post_rst_rx", 1, FRAME + 100);
        checkOutput("post_rst_byte", rxAt(0), 8'h3C);
        repeat (20) tick();
        clearRx();

        // Ten bytes through a four-entry FIFO exercise pointer wrap.
        for (int i = 0; i < 10; i++) begin
            for (int w = 0; w < 400 && fifo_full; w++) tick();
            applyStimulus(8'(i));
        end
        waitRx("wrap_rx", 10, 10 * FRAME + 300);
        for (int i = 0; i < 10; i++) checkOutput("wrap_order", rxAt(i), 8'(i));
        checkOutput("wrap_no_ovf", overflow, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule
